seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//   Parametrised multiplexed N-digit hex driver for common-anode 7-segment displays (BASYS3 4-digit unit by default).
//   Scans digits left to right, decodes hex to segments, adds per-digit decimal point, blanking and PWM brightness.
//   Double-buffers display data so a load never tears a frame; sits between game/score logic and the board pins.
// PARAMETERS
//   NUM_DIGITS   4       digits driven; index NUM_DIGITS-1 is left-most
//   SCAN_CYCLES  131072  clk cycles per digit slot; power of 2, >= 2**BRIGHT_W (use 8 in simulation)
//   BRIGHT_W     3       brightness control width
// PORTS
//   clk         in   1              100 MHz system clock
//   clear       in   1              synchronous active-high reset
//   load        in   1              capture strobe for digits/enables/dp_in
//   digits      in   4*NUM_DIGITS   hex values; digits[4k+3:4k] = digit k
//   enables     in   NUM_DIGITS     1 = digit k shown, 0 = blanked
//   dp_in       in   NUM_DIGITS     1 = decimal point of digit k lit
//   brightness  in   BRIGHT_W       duty: (brightness+1)/2**BRIGHT_W of each slot
//   AN          out  NUM_DIGITS     anodes, active low
//   C           out  7              cathodes CA..CG on C[6]..C[0], active low
//   DP          out  1              decimal point cathode, active low
//   frame_done  out  1              one-cycle pulse at every frame boundary
// BEHAVIOUR
//   One clock (clk); reset is synchronous and active-high on clear.
//   Reset: AN all 1, C = 7'h7F, DP = 1, frame_done = 0; tick_cnt = 0; slot = NUM_DIGITS-1; active and pending
//     buffers zeroed (enables 0 -> display dark until first load + boundary). clear mid-frame aborts the scan at once.
//   tick_cnt counts 0..SCAN_CYCLES-1 per slot; on wrap, slot decrements; slot 0 wraps to NUM_DIGITS-1.
//   Frame boundary = cycle where slot==0 and tick_cnt==SCAN_CYCLES-1.
//   load=1: digits/enables/dp_in captured into pending; several loads in a frame -> last wins.
//   At a boundary, pending copies into active; if load is high on that same cycle, active takes the live inputs
//     directly (and pending too), i.e. they show from the next frame's first slot.
//   frame_done is registered: high the cycle after each boundary, exactly one cycle.
//   brightness sampled at tick_cnt==0 of each slot, held for the slot.
//   lit = active_en[slot] && (tick_cnt[top BRIGHT_W bits] <= bright_q).
//   Outputs registered, 1-cycle latency from counter state:
//     AN = ~(lit << slot); C = lit ? ~seg(active_digit[slot]) : 7'h7F; DP = ~(lit && active_dp[slot]).
//   Only one AN bit low at any time; all AN high in the unlit part of a slot (ghosting guard).
//   Decode (active-high abcdefg): 0 7E,1 30,2 6D,3 79,4 33,5 5B,6 5F,7 70,8 7F,9 73,A 77,b 1F,c 0D,d 3D,E 4F,F 47.
//   Widths: tick_cnt $clog2(SCAN_CYCLES) bits, slot $clog2(NUM_DIGITS) bits (min 1); NUM_DIGITS=1 legal (slot fixed 0).
// STRUCTURE
//   Package seven_seg_pkg: SEG_BLANK = 7'h00, typedef logic [6:0] seg_t, function hex_to_seg(logic [3:0]) -> seg_t.
//   Sub-module hex_to_7seg (combinational, uses hex_to_seg); top holds counters, buffers, PWM and output regs.
// TESTING (NUM_DIGITS=4, SCAN_CYCLES=8, BRIGHT_W=2)
//   Reset: clear 3 cycles -> AN=4'hF, C=7'h7F, DP=1, frame_done=0; no AN low until a load crosses a boundary.
//   load digits=16'h12AF, enables=4'hF, dp=0, brightness=3 -> after boundary AN 0111/1011/1101/1110, 8 cycles each,
//     C = ~7'h30, ~7'h6D, ~7'h77, ~7'h47; frame_done pulses every 32 cycles.
//   brightness=1 -> each AN low for 4 of 8 cycles, AN=4'hF and C=7'h7F for other 4; brightness=0 -> 2 of 8.
//   Mid-frame load 16'h0000 then 16'h5555 -> current frame unchanged, next frame shows all 5 (~7'h5B); dp=4'b0100
//     -> DP low only during digit-2 slot; enables=4'b1010 -> digits 2 and 0 never drive AN low.
//   load on boundary cycle with 16'h9999 -> very next slot (digit 3) shows ~7'h73.
//   clear asserted mid digit-1 slot -> next cycle all outputs at reset values; scan restarts at digit 3 after release.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and the hex-to-segment decode table for the 7-segment scanner.
// Segment vectors are active-high abcdefg, with segment a in bit 6.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    seg_t seg;
    case (hex)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h73;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h0D;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-high segment pattern.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit common-anode hex display driver with double-buffered
// data, per-digit blanking and decimal point, and PWM brightness per slot.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_CYCLES = 131072,
  parameter int BRIGHT_W    = 3
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   enables,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              C,
  output logic                    DP,
  output logic                    frame_done
);

  localparam int TW = $clog2(SCAN_CYCLES);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

  logic [TW-1:0]         tick_q, tick_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [DW-1:0]         pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [DW-1:0]         act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  c_q, c_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  slot_wrap;
  logic                  boundary;
  logic                  lit;
  logic [3:0]            act_nib [NUM_DIGITS];
  logic [3:0]            sel_hex;
  seg_t                  sel_seg;

  assign slot_wrap = (tick_q == TICK_LAST);
  assign boundary  = slot_wrap && (slot_q == '0);

  // Scan runs right to left in slot index: left-most digit first.
  always_comb begin
    tick_d = slot_wrap ? '0 : tick_q + 1'b1;
    slot_d = slot_q;
    if (slot_wrap) begin
      slot_d = (slot_q == '0) ? SLOT_LAST : slot_q - 1'b1;
    end
  end

  // A load on the boundary cycle bypasses pending so it shows one frame sooner.
  always_comb begin
    pend_dig_d = load ? digits  : pend_dig_q;
    pend_en_d  = load ? enables : pend_en_q;
    pend_dp_d  = load ? dp_in   : pend_dp_q;
    act_dig_d  = act_dig_q;
    act_en_d   = act_en_q;
    act_dp_d   = act_dp_q;
    if (boundary) begin
      act_dig_d = load ? digits  : pend_dig_q;
      act_en_d  = load ? enables : pend_en_q;
      act_dp_d  = load ? dp_in   : pend_dp_q;
    end
  end

  assign bright_d = (tick_q == '0) ? brightness : bright_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign act_nib[gi] = act_dig_q[4*gi +: 4];
    end
  endgenerate

  assign sel_hex = act_nib[slot_q];

  hex_to_7seg u_dec (
    .hex_i (sel_hex),
    .seg_o (sel_seg)
  );

  // Anodes stay dark for the unlit tail of each slot to avoid ghosting.
  assign lit = act_en_q[slot_q] && (tick_q[TW-1 -: BRIGHT_W] <= bright_q);

  always_comb begin
    an_d = lit ? ~(NUM_DIGITS'(1) << slot_q) : '1;
    c_d  = lit ? ~sel_seg : ~SEG_BLANK;
    dp_d = ~(lit && act_dp_q[slot_q]);
    fd_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      tick_q     <= '0;
      slot_q     <= SLOT_LAST;
      pend_dig_q <= '0;
      pend_en_q  <= '0;
      pend_dp_q  <= '0;
      act_dig_q  <= '0;
      act_en_q   <= '0;
      act_dp_q   <= '0;
      bright_q   <= '0;
      an_q       <= '1;
      c_q        <= 7'h7F;
      dp_q       <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      slot_q     <= slot_d;
      pend_dig_q <= pend_dig_d;
      pend_en_q  <= pend_en_d;
      pend_dp_q  <= pend_dp_d;
      act_dig_q  <= act_dig_d;
      act_en_q   <= act_en_d;
      act_dp_q   <= act_dp_d;
      bright_q   <= bright_d;
      an_q       <= an_d;
      c_q        <= c_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign AN         = an_q;
  assign C          = c_q;
  assign DP         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a 4-digit, 8-cycle-slot configuration.
module tb_seven_seg_scanner;

  logic        clk;
  logic        clear;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  enables;
  logic [3:0]  dp_in;
  logic [1:0]  brightness;
  logic [3:0]  AN;
  logic [6:0]  C;
  logic        DP;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  // Cathode patterns {digit3, digit2, digit1, digit0}, active low.
  localparam logic [27:0] C_12AF = {7'h4F, 7'h12, 7'h08, 7'h38};
  localparam logic [27:0] C_5555 = {7'h24, 7'h24, 7'h24, 7'h24};
  localparam logic [27:0] C_9999 = {7'h0C, 7'h0C, 7'h0C, 7'h0C};

  seven_seg_scanner #(
    .NUM_DIGITS  (4),
    .SCAN_CYCLES (8),
    .BRIGHT_W    (2)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .load       (load),
    .digits     (digits),
    .enables    (enables),
    .dp_in      (dp_in),
    .brightness (brightness),
    .AN         (AN),
    .C          (C),
    .DP         (DP),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic chk(input string tag, input logic [3:0] an_e, input logic [6:0] c_e,
                     input logic dp_e, input logic fd_e);
    checks++;
    assert (AN === an_e) else begin
      failures++;
      $error("FAIL %s n=%0d AN got=%b want=%b", tag, n, AN, an_e);
    end
    checks++;
    assert (C === c_e) else begin
      failures++;
      $error("FAIL %s n=%0d C got=%h want=%h", tag, n, C, c_e);
    end
    checks++;
    assert (DP === dp_e) else begin
      failures++;
      $error("FAIL %s n=%0d DP got=%b want=%b", tag, n, DP, dp_e);
    end
    checks++;
    assert (frame_done === fd_e) else begin
      failures++;
      $error("FAIL %s n=%0d frame_done got=%b want=%b", tag, n, frame_done, fd_e);
    end
  endtask

  // Outputs seen at count n belong to scan position n-1 (one register stage);
  // position p sits in digit 3-(p%32)/8 at tick p%8, and frame_done follows
  // the last tick of each 32-cycle frame.
  task automatic run_chk(input int cnt, input logic [27:0] cexp, input logic [3:0] en,
                         input logic [3:0] dpm, input int lit_ticks, input string tag);
    for (int k = 0; k < cnt; k++) begin
      int p, d, t;
      logic lit;
      step();
      p   = n - 1;
      d   = 3 - (p % 32) / 8;
      t   = p % 8;
      lit = en[d] && (t < lit_ticks);
      chk(tag,
          lit ? ~(4'b0001 << d) : 4'hF,
          lit ? cexp[d*7 +: 7] : 7'h7F,
          ~(lit && dpm[d]),
          (n % 32) == 0);
      $display("step %s n=%0d AN=%b C=%h DP=%b fd=%b", tag, n, AN, C, DP, frame_done);
    end
  endtask

  initial begin
    clear      = 1'b1;
    load       = 1'b0;
    digits     = 16'h0000;
    enables    = 4'h0;
    dp_in      = 4'h0;
    brightness = 2'd3;
    repeat (3) step();
    chk("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    clear = 1'b0;
    n     = 0;

    // Nothing loaded: dark through the first boundary.
    run_chk(40, C_12AF, 4'h0, 4'h0, 8, "dark");
    digits  = 16'h12AF;
    enables = 4'hF;
    dp_in   = 4'h0;
    load    = 1'b1;
    run_chk(1, C_12AF, 4'h0, 4'h0, 8, "load_12AF");
    load = 1'b0;
    run_chk(23, C_12AF, 4'h0, 4'h0, 8, "pend_hidden");
    run_chk(32, C_12AF, 4'hF, 4'h0, 8, "frame_12AF");

    brightness = 2'd1;
    run_chk(32, C_12AF, 4'hF, 4'h0, 4, "bright1");
    brightness = 2'd0;
    run_chk(32, C_12AF, 4'hF, 4'h0, 2, "bright0");

    // Two loads mid-frame: current frame untouched, last one wins next frame.
    brightness = 2'd3;
    digits     = 16'h0000;
    load       = 1'b1;
    run_chk(1, C_12AF, 4'hF, 4'h0, 8, "midload_a");
    digits = 16'h5555;
    dp_in  = 4'b0100;
    run_chk(1, C_12AF, 4'hF, 4'h0, 8, "midload_b");
    load = 1'b0;
    run_chk(30, C_12AF, 4'hF, 4'h0, 8, "cur_frame");
    run_chk(32, C_5555, 4'hF, 4'b0100, 8, "frame_5555");

    enables = 4'b1010;
    load    = 1'b1;
    run_chk(1, C_5555, 4'hF, 4'b0100, 8, "en_load");
    load = 1'b0;
    run_chk(31, C_5555, 4'hF, 4'b0100, 8, "frame_5555b");
    run_chk(32, C_5555, 4'b1010, 4'b0100, 8, "en_1010");
    run_chk(31, C_5555, 4'b1010, 4'b0100, 8, "en_1010b");

    // Load exactly on the boundary cycle: shows from the very next slot.
    digits  = 16'h9999;
    enables = 4'hF;
    dp_in   = 4'h0;
    load    = 1'b1;
    run_chk(1, C_5555, 4'b1010, 4'b0100, 8, "bnd_load");
    load = 1'b0;
    run_chk(18, C_9999, 4'hF, 4'h0, 8, "bnd_frame");

    // Clear in the middle of the digit-1 slot.
    clear = 1'b1;
    step();
    chk("clear_mid", 4'hF, 7'h7F, 1'b1, 1'b0);
    clear   = 1'b0;
    n       = 0;
    digits  = 16'h9999;
    enables = 4'hF;
    dp_in   = 4'b0001;
    load    = 1'b1;
    run_chk(1, C_9999, 4'h0, 4'h0, 8, "post_clr");
    load = 1'b0;
    run_chk(31, C_9999, 4'h0, 4'h0, 8, "post_clr_dark");
    run_chk(32, C_9999, 4'hF, 4'b0001, 8, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
